// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, instruction register and a two-state
// FETCH/HALTED controller with redirect, stall, halt-on-opcode and resume.
module fetch_unit #(
    parameter logic [9:0] RESET_VECTOR = 10'd0,
    parameter logic [5:0] HALT_OPCODE  = 6'b011101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [9:0]  redirect_target,
    input  logic        resume,
    output logic [9:0]  addy,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [9:0]  pc_of_instr,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [9:0]  pc, pc_next;
    logic [31:0] ir, ir_next;
    logic [9:0]  pc_of, pc_of_next;
    logic        vld, vld_next;
    logic [15:0] count, count_next;

    // Accepted-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            pc    <= RESET_VECTOR;
            ir    <= 32'h0;
            pc_of <= 10'd0;
            vld   <= 1'b0;
            count <= 16'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            pc_of <= pc_of_next;
            vld   <= vld_next;
            count <= count_next;
        end
    end

    // Next-state logic: redirect beats stall beats fetch; HALTED waits for resume.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        pc_of_next = pc_of;
        vld_next   = vld;
        count_next = count;
        case (state)
            S_FETCH: begin
                if (redirect_en) begin
                    // Word fetched this cycle is squashed, even a halt word.
                    pc_next  = redirect_target;
                    vld_next = 1'b0;
                end else if (!stall) begin
                    ir_next    = instr_in;
                    pc_of_next = pc;
                    vld_next   = 1'b1;
                    count_next = sat_inc(count);
                    if (instr_in[31:26] == HALT_OPCODE) begin
                        state_next = S_HALTED;
                    end else begin
                        pc_next = pc + 10'd1;
                    end
                end
            end
            S_HALTED: begin
                // The halt word stays visible only during the first HALTED cycle.
                vld_next = 1'b0;
                if (resume) begin
                    state_next = S_FETCH;
                    pc_next    = redirect_en ? redirect_target : pc + 10'd1;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign addy        = pc;
    assign instr_out   = ir;
    assign instr_valid = vld;
    assign pc_of_instr = pc_of;
    assign halted      = (state == S_HALTED);
    assign fetch_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, behavioural reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam logic [5:0]  HALT = 6'b011101;
    localparam logic [31:0] HALT_WORD = {HALT, 26'd0};

    logic        clock;
    logic        reset;
    logic [31:0] instr_in;
    logic        stall;
    logic        redirect_en;
    logic [9:0]  redirect_target;
    logic        resume;
    logic [9:0]  addy;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [9:0]  pc_of_instr;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [1024];
    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    // Reference model state
    int          m_pc;
    logic [31:0] m_ir;
    int          m_pc_of;
    bit          m_vld;
    bit          m_halted;
    int          m_cnt;

    fetch_unit #(.RESET_VECTOR(10'd0), .HALT_OPCODE(HALT)) dut (
        .clock(clock),
        .reset(reset),
        .instr_in(instr_in),
        .stall(stall),
        .redirect_en(redirect_en),
        .redirect_target(redirect_target),
        .resume(resume),
        .addy(addy),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc_of_instr(pc_of_instr),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    assign instr_in = mem[addy];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch unit must do each edge, in plain arithmetic.
    always @(posedge clock or negedge reset) begin
        logic [31:0] word;
        if (!reset) begin
            m_pc = 0; m_ir = 32'h0; m_pc_of = 0; m_vld = 0; m_halted = 0; m_cnt = 0;
        end else if (!m_halted) begin
            if (redirect_en) begin
                m_pc = int'(redirect_target);
                m_vld = 0;
            end else if (!stall) begin
                word = mem[m_pc];
                m_ir = word;
                m_pc_of = m_pc;
                m_vld = 1;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                if (word[31:26] == HALT) m_halted = 1;
                else m_pc = (m_pc + 1) % 1024;
            end
        end else begin
            m_vld = 0;
            if (resume) begin
                m_halted = 0;
                m_pc = redirect_en ? int'(redirect_target) : (m_pc + 1) % 1024;
            end
        end
    end

    // Compare DUT against model on every falling edge while out of reset.
    always @(negedge clock) begin
        if (reset && cmp_en) begin
            chk("m_addy",   {22'd0, addy},        m_pc);
            chk("m_instr",  instr_out,            m_ir);
            chk("m_valid",  {31'd0, instr_valid}, {31'd0, m_vld});
            chk("m_pc_of",  {22'd0, pc_of_instr}, m_pc_of);
            chk("m_halted", {31'd0, halted},      {31'd0, m_halted});
            chk("m_count",  {16'd0, fetch_count}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = k;
        stall = 0; redirect_en = 0; redirect_target = 10'd0; resume = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_addy",  {22'd0, addy}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_count", {16'd0, fetch_count}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_halt",  {31'd0, halted}, 32'd0);
        @(negedge clock); #1;
        reset = 1'b1;
        cmp_en = 1;

        // Sequential fetch
        repeat (3) tick();
        chk("seq_addy",  {22'd0, addy}, 32'd3);
        chk("seq_count", {16'd0, fetch_count}, 32'd3);
        chk("seq_instr", instr_out, 32'd2);
        chk("seq_pcof",  {22'd0, pc_of_instr}, 32'd2);

        // Stall two cycles at PC=5
        redirect_en = 1; redirect_target = 10'd5; tick();
        redirect_en = 0;
        chk("rd5_valid", {31'd0, instr_valid}, 32'd0);
        stall = 1; tick(); tick();
        chk("stl_addy",  {22'd0, addy}, 32'd5);
        chk("stl_count", {16'd0, fetch_count}, 32'd3);
        stall = 0; tick();
        chk("stl_rel_addy",  {22'd0, addy}, 32'd6);
        chk("stl_rel_instr", instr_out, 32'd5);
        tick();
        chk("pc7_addy", {22'd0, addy}, 32'd7);

        // Redirect during stall at PC=7
        redirect_en = 1; stall = 1; redirect_target = 10'd1; tick();
        redirect_en = 0; stall = 0;
        chk("rdst_addy",  {22'd0, addy}, 32'd1);
        chk("rdst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rdst_count", {16'd0, fetch_count}, 32'd5);

        // Halt at addy 2, then resume
        mem[2] = HALT_WORD;
        tick(); tick();
        chk("hlt_instr",  instr_out, HALT_WORD);
        chk("hlt_valid",  {31'd0, instr_valid}, 32'd1);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_addy",   {22'd0, addy}, 32'd2);
        stall = 1; redirect_en = 1; redirect_target = 10'd50; tick();
        stall = 0; redirect_en = 0;
        chk("hlt2_valid", {31'd0, instr_valid}, 32'd0);
        chk("hlt2_addy",  {22'd0, addy}, 32'd2);
        resume = 1; tick();
        resume = 0;
        chk("res_addy",   {22'd0, addy}, 32'd3);
        chk("res_halted", {31'd0, halted}, 32'd0);
        chk("res_valid",  {31'd0, instr_valid}, 32'd0);
        tick();
        resume = 1; tick();  // resume ignored in FETCH
        resume = 0;
        chk("fres_addy", {22'd0, addy}, 32'd5);

        // Redirect coinciding with halt fetch
        redirect_en = 1; redirect_target = 10'd2; tick();
        redirect_target = 10'd20; tick();
        redirect_en = 0;
        chk("rdh_addy",   {22'd0, addy}, 32'd20);
        chk("rdh_halted", {31'd0, halted}, 32'd0);

        // Resume with redirect
        redirect_en = 1; redirect_target = 10'd2; tick();
        redirect_en = 0; tick();
        resume = 1; redirect_en = 1; redirect_target = 10'd100; tick();
        resume = 0; redirect_en = 0;
        chk("resrd_addy", {22'd0, addy}, 32'd100);

        // PC wrap
        redirect_en = 1; redirect_target = 10'd1023; tick();
        redirect_en = 0; tick();
        chk("wrap_addy", {22'd0, addy}, 32'd0);
        chk("wrap_pcof", {22'd0, pc_of_instr}, 32'd1023);

        // Async reset while HALTED at PC=9
        mem[9] = HALT_WORD;
        redirect_en = 1; redirect_target = 10'd9; tick();
        redirect_en = 0; tick();
        chk("h9_halted", {31'd0, halted}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_addy",   {22'd0, addy}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("arst_count",  {16'd0, fetch_count}, 32'd0);
        chk("arst_instr",  instr_out, 32'd0);
        chk("arst_pcof",   {22'd0, pc_of_instr}, 32'd0);
        @(posedge clock); @(negedge clock); #1;
        mem[2] = 32'd2; mem[9] = 32'd9;
        reset = 1'b1;
        tick();
        chk("post_addy",  {22'd0, addy}, 32'd1);
        chk("post_count", {16'd0, fetch_count}, 32'd1);

        // Counter saturation
        repeat (65534) tick();
        chk("sat_count", {16'd0, fetch_count}, 32'hFFFF);
        repeat (3) tick();
        chk("sat_hold", {16'd0, fetch_count}, 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 10'd0: PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 6'b011101: opcode field value that halts fetch.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_in  input  32  instruction word returned by instruction memory for the current addy.
REQ-006 SHALL have port stall  input  1  level; downstream cannot accept a new instruction this cycle.
REQ-007 SHALL have port redirect_en  input  1  one-cycle pulse; taken jump/branch from execute.
REQ-008 SHALL have port redirect_target  input  10  target instruction address for redirect_en.
REQ-009 SHALL have port resume  input  1  one-cycle pulse; leave HALTED.
REQ-010 SHALL have port addy  output  10  instruction memory address; equals PC combinationally.
REQ-011 SHALL have port instr_out  output  32  instruction register (IR) contents.
REQ-012 SHALL have port instr_valid  output  1  IR holds a live instruction for decode.
REQ-013 SHALL have port pc_of_instr  output  10  address from which instr_out was fetched.
REQ-014 SHALL have port halted  output  1  high while in HALTED.
REQ-015 SHALL have port fetch_count  output  16  count of instructions accepted into IR.

Function
REQ-016 SHALL implement a two-state FSM: FETCH, HALTED.
REQ-017 SHALL, in FETCH with redirect_en=1 (highest priority), load PC<=redirect_target, clear instr_valid, leave IR/pc_of_instr/fetch_count unchanged (fetched word squashed), stay FETCH.
REQ-018 SHALL, in FETCH with redirect_en=0 and stall=1, hold PC, IR, pc_of_instr, instr_valid, fetch_count unchanged.
REQ-019 SHALL, in FETCH with redirect_en=0, stall=0, load IR<=instr_in, pc_of_instr<=PC, instr_valid<=1, increment fetch_count.
REQ-020 SHALL, in the REQ-019 case, set PC<=PC+1 when instr_in[31:26]!=HALT_OPCODE.
REQ-021 SHALL, in the REQ-019 case with instr_in[31:26]==HALT_OPCODE, hold PC and go to HALTED; the halt word is still presented in IR with instr_valid=1 for that one cycle.
REQ-022 SHALL, in HALTED, drive halted=1, clear instr_valid after the first HALTED cycle, hold PC/IR/fetch_count, and ignore stall and redirect_en when resume=0.
REQ-023 SHALL, in HALTED with resume=1, go to FETCH with PC<=redirect_target if redirect_en=1, else PC<=PC+1; instr_valid stays 0 that cycle.
REQ-024 SHALL wrap PC modulo 1024 (10'd1023+1 -> 10'd0) with no flag.
REQ-025 SHALL saturate fetch_count at 16'hFFFF.
REQ-026 SHALL have zero-cycle latency addy=PC and one-cycle latency from addy change to IR capture.
REQ-027 SHALL treat a redirect coinciding with a HALT_OPCODE fetch as a redirect (no halt).
REQ-028 SHALL ignore resume while in FETCH.

Reset
REQ-029 SHALL, on reset=0 at any time (asynchronously, including mid-stall or in HALTED), force state FETCH, PC=RESET_VECTOR, IR=32'h0, pc_of_instr=10'd0, instr_valid=0, halted=0, fetch_count=0.
REQ-030 SHALL begin fetching from RESET_VECTOR on the first rising edge with reset=1.

Verification
REQ-031 Sequential fetch: reset, release, memory returns word k at addy k, no stall -> addy 0,1,2,3; instr_out = word at pc_of_instr one cycle later; fetch_count=3 after 3 edges.
REQ-032 Stall: assert stall 2 cycles at PC=5 -> addy stays 5, instr_out/instr_valid/fetch_count frozen; fetch resumes at 5 then 6.
REQ-033 Redirect with stall: redirect_en=1, stall=1, target 10'd1 at PC=7 -> next addy=1, instr_valid=0, fetch_count unchanged.
REQ-034 Halt/resume: word 32'b011101_0...0 at addy 2 -> instr_out shows it with instr_valid=1 one cycle, halted=1, addy holds 2; resume pulse -> addy=3, halted=0.
REQ-035 Wrap and saturation: force PC to 1023 with redirect -> next addy 0; preload 65535 fetches -> fetch_count stays 16'hFFFF.
REQ-036 Async reset mid-operation: drop reset between edges while HALTED at PC=9 -> outputs reach reset values immediately, before next clock edge.
